gate_tt_sequencer: RTL and testbench

Controller that sequences a combinational N-input gate-under-test (such as the 2-input Guia_0501 gate) through every input combination in ascending order. It holds each vector stable for a programmable settle time, samples the gate output, and assembles the full truth table in a result register. It sits between a start/done handshake from a lab top-level or testbench and the gate's input/output pins, replacing hand-written #1 stimulus sequences.

---
 rtl/gate_tt_sequencer.sv | 131 +++++++++++++
 tb/tb_gate_tt_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_sequencer.sv
// Sweeps a combinational gate-under-test through every input vector and builds its truth table.
// Optional self-check (expected/pass ports) is enabled with `define GATE_TT_CHECK_EN.
module gate_tt_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 gate_out,
`ifdef GATE_TT_CHECK_EN
    input  logic [2**N_IN-1:0]   expected,
    output logic                 pass,
`endif
    output logic [N_IN-1:0]      in_vec,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   result
);

    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST     = '1;
    localparam logic [N_IN-1:0] ONE      = N_IN'(1);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [N_IN-1:0]     in_vec_n;
    logic                busy_n, done_n;
    logic [2**N_IN-1:0]  result_n;
`ifdef GATE_TT_CHECK_EN
    logic [2**N_IN-1:0]  exp_q, exp_n;
    logic                pass_n;
`endif

    // State and every output live in this one register bank so nothing reaches a port combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            in_vec <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef GATE_TT_CHECK_EN
            exp_q  <= '0;
            pass   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            in_vec <= in_vec_n;
            busy   <= busy_n;
            done   <= done_n;
            result <= result_n;
`ifdef GATE_TT_CHECK_EN
            exp_q  <= exp_n;
            pass   <= pass_n;
`endif
        end
    end

    // Next-state logic: each vector is held SETTLE+1 clocks, sampled on the last one, then advanced.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        in_vec_n = in_vec;
        busy_n   = busy;
        done_n   = done;
        result_n = result;
`ifdef GATE_TT_CHECK_EN
        exp_n    = exp_q;
        pass_n   = pass;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    in_vec_n = '0;
                    result_n = '0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = HOLD;
`ifdef GATE_TT_CHECK_EN
                    exp_n    = expected;
                    pass_n   = 1'b0;
`endif
                end
            end
            HOLD: begin
                if (cnt == SETTLE_C) begin
                    result_n[in_vec] = gate_out;
                    cnt_n            = '0;
                    if (in_vec == LAST) begin
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        in_vec_n = '0;
                        state_n  = DONE;
`ifdef GATE_TT_CHECK_EN
                        pass_n   = (result_n == exp_q);
`endif
                    end else begin
                        in_vec_n = in_vec + ONE;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: begin
                done_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides sampling and the done pulse, and discards any partial table.
        if (abort && state != IDLE) begin
            state_n  = IDLE;
            cnt_n    = '0;
            in_vec_n = '0;
            busy_n   = 1'b0;
            done_n   = 1'b0;
            result_n = '0;
`ifdef GATE_TT_CHECK_EN
            pass_n   = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: table of gate sweeps plus hand-written abort/reset/settle sequences.
module tb_gate_tt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, start3;
    logic [1:0] sel;
    logic [1:0] in_vec, in_vec3;
    logic       busy, done, busy3, done3;
    logic [3:0] result, result3;
    logic       gate_out, gate_out3;
`ifdef GATE_TT_CHECK_EN
    logic [3:0] expected, expected3;
    logic       pass, pass3;
    logic       bad_exp;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] sb[$];

    typedef struct {
        logic [1:0] sel;
        logic [3:0] exp_res;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    // Gate-under-test models: 0 AND, 1 XOR, 2 OR, 3 NAND; in_vec[1] is a, in_vec[0] is b.
    function automatic logic gate_fn(input logic [1:0] s, input logic [1:0] v);
        case (s)
            2'd0:    return v[1] & v[0];
            2'd1:    return v[1] ^ v[0];
            2'd2:    return v[1] | v[0];
            default: return ~(v[1] & v[0]);
        endcase
    endfunction

    assign gate_out  = gate_fn(sel, in_vec);
    assign gate_out3 = gate_fn(2'd3, in_vec3);

    gate_tt_sequencer #(.N_IN(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_out(gate_out),
`ifdef GATE_TT_CHECK_EN
        .expected(expected), .pass(pass),
`endif
        .in_vec(in_vec), .busy(busy), .done(done), .result(result)
    );

    gate_tt_sequencer #(.N_IN(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .gate_out(gate_out3),
`ifdef GATE_TT_CHECK_EN
        .expected(expected3), .pass(pass3),
`endif
        .in_vec(in_vec3), .busy(busy3), .done(done3), .result(result3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One full sweep on the default instance; the expected table is queued when start is driven.
    task automatic applyStimulus(input logic [1:0] s, input logic [3:0] exp_res);
        int k;
        @(negedge clk);
        sel   = s;
        start = 1'b1;
`ifdef GATE_TT_CHECK_EN
        expected = bad_exp ? 4'b1001 : exp_res;
`endif
        sb.push_back(exp_res);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        checkOutput("result_cleared_at_start", result, 0);
`ifdef GATE_TT_CHECK_EN
        checkOutput("pass_cleared_at_start", pass, 0);
`endif
        while (!done && k < 40) begin
            checkOutput("in_vec_step", in_vec, k / 2);
            checkOutput("busy_during_sweep", busy, 1);
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checkOutput("done_timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            checkOutput("done_latency", k, 8);
            checkOutput("result", result, sb.pop_front());
            checkOutput("busy_at_done", busy, 0);
            checkOutput("in_vec_at_done", in_vec, 0);
`ifdef GATE_TT_CHECK_EN
            checkOutput("pass", pass, bad_exp ? 0 : 1);
`endif
            @(negedge clk);
            checkOutput("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int k;
        int seen;
        vecs[0] = '{2'd0, 4'b1000};
        vecs[1] = '{2'd1, 4'b0110};
        vecs[2] = '{2'd2, 4'b1110};
        vecs[3] = '{2'd3, 4'b0111};

        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0; sel = 2'd0;
`ifdef GATE_TT_CHECK_EN
        expected = 4'b0; expected3 = 4'b0; bad_exp = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_in_vec", in_vec, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        rst_n = 1'b1;

        // AND, then XOR and OR back to back, then NAND
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i].sel, vecs[i].exp_res);

        // abort while idle must leave the previous table alone
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("abort_idle_result", result, 4'b0111);
        checkOutput("abort_idle_busy", busy, 0);

        // SETTLE=3 NAND sweep with ignored start pulses at +5 and +8
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        k = 0;
        while (!done3 && k < 60) begin
            checkOutput("s3_in_vec_step", in_vec3, k / 4);
            checkOutput("s3_busy", busy3, 1);
            start3 = (k == 4 || k == 7);
            @(negedge clk);
            k++;
        end
        start3 = 1'b0;
        checkOutput("s3_done_seen", done3, 1);
        checkOutput("s3_latency", k, 16);
        checkOutput("s3_result", result3, 4'b0111);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy3 || done3) seen++;
        end
        checkOutput("s3_no_queued_start", seen, 0);

        // abort three clocks into a NAND sweep
        @(negedge clk); sel = 2'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_abort_result", result, 4'b0001);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_in_vec", in_vec, 0);
        checkOutput("abort_result", result, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput("abort_no_done", seen, 0);

        // asynchronous reset mid-sweep, checked between clock edges
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_in_vec", in_vec, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_in_vec", in_vec, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_result", result, 0);
        @(negedge clk); rst_n = 1'b1;

`ifdef GATE_TT_CHECK_EN
        bad_exp = 1'b1;
        applyStimulus(2'd0, 4'b1000);
        bad_exp = 1'b0;
        applyStimulus(2'd0, 4'b1000);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("abort_clears_pass", pass, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
